// File: rtl/instr_trace_encoder_if.sv
// rtl/instr_trace_encoder_if.sv - control-bus snoop and trace-record stream bundle for instr_trace_encoder
//
// Purpose: groups every non-clock, non-reset signal of the trace encoder.
// Ports (signals):
//   state_i, d_addr_i, d_wr_i, rf_s_i, rf_w_addr_i, rf_ra_addr_i, rf_rb_addr_i,
//   rf_w_wr_i, rf_ra_rd_i, rf_rb_rd_i, alu_s_i, out_ready -> driven by master
//   out_valid, out_word, out_seq, out_mismatch, overflow, halted, level -> driven by slave
// Modports: master (controller/consumer side), slave (encoder side).

interface instr_trace_encoder_if #(
    parameter int DEPTH = 8
);
    logic [3:0]               state_i;
    logic [7:0]               d_addr_i;
    logic                     d_wr_i;
    logic                     rf_s_i;
    logic [3:0]               rf_w_addr_i;
    logic [3:0]               rf_ra_addr_i;
    logic [3:0]               rf_rb_addr_i;
    logic                     rf_w_wr_i;
    logic                     rf_ra_rd_i;
    logic                     rf_rb_rd_i;
    logic [2:0]               alu_s_i;
    logic                     out_ready;
    logic                     out_valid;
    logic [15:0]              out_word;
    logic [7:0]               out_seq;
    logic                     out_mismatch;
    logic                     overflow;
    logic                     halted;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output state_i, d_addr_i, d_wr_i, rf_s_i, rf_w_addr_i, rf_ra_addr_i,
               rf_rb_addr_i, rf_w_wr_i, rf_ra_rd_i, rf_rb_rd_i, alu_s_i, out_ready,
        input  out_valid, out_word, out_seq, out_mismatch, overflow, halted, level
    );

    modport slave (
        input  state_i, d_addr_i, d_wr_i, rf_s_i, rf_w_addr_i, rf_ra_addr_i,
               rf_rb_addr_i, rf_w_wr_i, rf_ra_rd_i, rf_rb_rd_i, alu_s_i, out_ready,
        output out_valid, out_word, out_seq, out_mismatch, overflow, halted, level
    );
endinterface

// File: rtl/instr_trace_encoder.sv
// rtl/instr_trace_encoder.sv - re-encodes retired instructions from controller state into a trace FIFO
//
// Purpose: snoops the processor controller, rebuilds each retired 16-bit
// instruction word, checks the control signature against the opcode and
// queues {mismatch, seq, word} records for a valid/ready consumer.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - instr_trace_encoder_if.slave (controller snoop inputs, record stream, status)

module instr_trace_encoder #(
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_trace_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_NOOP   = 4'd3;
    localparam logic [3:0] ST_LOAD_B = 4'd5;
    localparam logic [3:0] ST_STORE  = 4'd6;
    localparam logic [3:0] ST_ADD    = 4'd7;
    localparam logic [3:0] ST_SUB    = 4'd8;
    localparam logic [3:0] ST_HALT   = 4'd9;

    logic [3:0]    prev_state;
    logic          retire;
    logic          halt_entry;
    logic          capture;
    logic [15:0]   cap_word;
    logic          cap_mismatch;

    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    seq;
    logic          overflow_q;
    logic          halted_q;
    logic          pop;
    logic          push;
    logic [24:0]   head;

    // Back in FETCH after an execute state means that instruction retired; the
    // bus still carries the values the controller registered while executing.
    always_comb begin
        retire = (bus.state_i == ST_FETCH) &&
                 (prev_state inside {ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB});
        halt_entry = (bus.state_i == ST_HALT) && (prev_state != ST_HALT);
        capture = retire || halt_entry;

        cap_word     = 16'h0000;
        cap_mismatch = 1'b0;
        if (halt_entry) begin
            cap_word = 16'h5000;
        end else begin
            case (prev_state)
                ST_LOAD_B: begin
                    cap_word     = {4'b0010, bus.d_addr_i, bus.rf_w_addr_i};
                    cap_mismatch = !(bus.rf_s_i && bus.rf_w_wr_i && !bus.d_wr_i);
                end
                ST_STORE: begin
                    cap_word     = {4'b0001, bus.rf_ra_addr_i, bus.d_addr_i};
                    cap_mismatch = !(bus.d_wr_i && bus.rf_ra_rd_i && !bus.rf_w_wr_i);
                end
                ST_ADD, ST_SUB: begin
                    cap_word     = {(prev_state == ST_ADD) ? 4'b0011 : 4'b0100,
                                    bus.rf_ra_addr_i, bus.rf_rb_addr_i, bus.rf_w_addr_i};
                    cap_mismatch = !(!bus.rf_s_i && bus.rf_w_wr_i && bus.rf_ra_rd_i &&
                                     bus.rf_rb_rd_i &&
                                     (bus.alu_s_i == ((prev_state == ST_ADD) ? 3'd1 : 3'd2)));
                end
                default: begin
                    cap_word     = 16'h0000;
                    cap_mismatch = 1'b0;
                end
            endcase
        end
    end

    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign pop  = (count != '0) && bus.out_ready;
    assign push = capture && ((count != FULL_LEVEL) || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_state <= ST_INIT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= 8'd0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            prev_state <= bus.state_i;
            // Dropped captures still consume a sequence number.
            if (capture)
                seq <= seq + 8'd1;
            if (capture && !push)
                overflow_q <= 1'b1;
            if (halt_entry)
                halted_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push)
            mem[wr_ptr] <= {cap_mismatch, seq, cap_word};
    end

    // Head fields read as zero while empty so reset shows a clean record.
    assign head             = mem[rd_ptr];
    assign bus.out_valid    = (count != '0);
    assign bus.out_word     = bus.out_valid ? head[15:0]  : 16'h0000;
    assign bus.out_seq      = bus.out_valid ? head[23:16] : 8'd0;
    assign bus.out_mismatch = bus.out_valid ? head[24]    : 1'b0;
    assign bus.overflow     = overflow_q;
    assign bus.halted       = halted_q;
    assign bus.level        = count;
endmodule
